// File: rtl/array_frame_collector.sv
// Purpose: gathers DEPTH scalar elements from b_in (store or accumulate) and emits them as one packed frame on b_out.
// Latency: b_out_notify rises one cycle after the last element transfer; the next element is taken the cycle after acceptance.
// Backpressure: b_in_notify drops while a frame is pending; the frame is held stable until b_out_sync accepts it.
module array_frame_collector #(
   parameter int ELEM_W   = 32,
   parameter int DEPTH    = 2,
   parameter int ACC_MODE = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic [ELEM_W-1:0]            b_in,
   input  logic                         b_in_sync,
   output logic                         b_in_notify,
   output logic [DEPTH*ELEM_W-1:0]      b_out,
   input  logic                         b_out_sync,
   output logic                         b_out_notify,
   output logic [$clog2(DEPTH+1)-1:0]   fill_count
);

   // A one-element frame still needs a one-bit index register.
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic {
      ST_RX = 1'b0,
      ST_TX = 1'b1
   } state_t;

   state_t                    state_q;
   state_t                    state_d;
   logic [DEPTH*ELEM_W-1:0]   arr_q;
   logic [DEPTH*ELEM_W-1:0]   arr_d;
   logic [DEPTH*ELEM_W-1:0]   frame_q;
   logic [IDX_W-1:0]          idx_q;
   logic [CNT_W-1:0]          fill_q;
   logic [ELEM_W-1:0]         cur_elem;
   logic [ELEM_W-1:0]         new_elem;
   logic                      in_xfer;
   logic                      out_xfer;
   logic                      last_elem;

   // Handshakes only count in the state that owns the respective channel.
   assign in_xfer   = (state_q == ST_RX) && b_in_sync;
   assign out_xfer  = (state_q == ST_TX) && b_out_sync;
   assign last_elem = (idx_q == LAST_IDX);

   // Read the element currently addressed by the write index.
   always_comb begin
      cur_elem = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_elem = arr_q[i*ELEM_W +: ELEM_W];
         end
      end
   end

   // Store overwrites; accumulate adds modulo 2^ELEM_W (carry dropped by width).
   always_comb begin
      if (ACC_MODE != 0) begin
         new_elem = cur_elem + b_in;
      end else begin
         new_elem = b_in;
      end
   end

   // Array image with the incoming element merged in, so the frame can capture it on the same edge.
   always_comb begin
      arr_d = arr_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (idx_q == IDX_W'(i)) begin
            arr_d[i*ELEM_W +: ELEM_W] = new_elem;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_RX;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; clear overrides both handshakes.
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = ST_RX;
      end else begin
         case (state_q)
            ST_RX:   if (in_xfer && last_elem) state_d = ST_TX;
            ST_TX:   if (out_xfer)             state_d = ST_RX;
            default: state_d = ST_RX;
         endcase
      end
   end

   // FSM outputs decoded from state, so an asynchronous reset reaches them immediately.
   always_comb begin
      b_in_notify  = 1'b0;
      b_out_notify = 1'b0;
      case (state_q)
         ST_RX:   b_in_notify  = 1'b1;
         ST_TX:   b_out_notify = 1'b1;
         default: b_in_notify  = 1'b1;
      endcase
   end

   // Datapath: array, write index, fill counter and captured frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         arr_q   <= '0;
         idx_q   <= '0;
         fill_q  <= '0;
         frame_q <= '0;
      end else if (clear) begin
         arr_q   <= '0;
         idx_q   <= '0;
         fill_q  <= '0;
         frame_q <= '0;
      end else if (in_xfer) begin
         arr_q <= arr_d;
         if (last_elem) begin
            idx_q   <= '0;
            fill_q  <= FULL_CNT;
            frame_q <= arr_d;
         end else begin
            idx_q  <= idx_q + IDX_W'(1);
            fill_q <= fill_q + CNT_W'(1);
         end
      end else if (out_xfer) begin
         // Frame stays on b_out after acceptance; only the count restarts.
         fill_q <= '0;
      end
   end

   assign b_out      = frame_q;
   assign fill_count = fill_q;

endmodule

// File: doc/array_frame_collector.md
Name: array_frame_collector

Overview:
- Parametrised successor of the single-array blocking-port module.
- Collects DEPTH scalar elements, arriving one per handshake on the b_in channel, into an internal array.
- Emits the whole array as one packed frame on the b_out channel through a blocking sync/notify handshake.
- Adds a selectable store or accumulate mode, a fill counter and a synchronous clear.
- Sits between a scalar producer and an array consumer in the generated top level.

Parameters:
ELEM_W, 32, width of one array element and of b_in.
DEPTH, 2, number of elements per frame; legal range 1..64.
ACC_MODE, 0, 0 = store (element overwritten by b_in); 1 = accumulate (element <= element + b_in, modulo 2^ELEM_W).

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-low reset.
clear  input  1  synchronous clear of array, index and state.
b_in  input  ELEM_W  incoming element.
b_in_sync  input  1  producer has valid data on b_in.
b_in_notify  output  1  block can accept an element.
b_out  output  DEPTH*ELEM_W  packed frame; element i is at bits [i*ELEM_W +: ELEM_W].
b_out_sync  input  1  consumer accepts the frame.
b_out_notify  output  1  frame on b_out is valid.
fill_count  output  $clog2(DEPTH+1)  number of elements written in the current frame.

Behaviour:
Reset (rst low, asynchronous):
- State RX; b_in_notify=1; b_out_notify=0; b_out=0; array=0; index=0; fill_count=0.

Input transfer:
- Occurs on a clock edge where b_in_notify=1 and b_in_sync=1.
- Action: array[index] <= b_in (ACC_MODE=0) or array[index] + b_in (ACC_MODE=1, carry discarded).
- Then index and fill_count increment.

State RX:
- b_in_notify=1, b_out_notify=0.
- If a transfer occurs with index==DEPTH-1, on that same edge:
  - b_in_notify<=0; b_out_notify<=1;
  - b_out<=packed array including the element just written;
  - index<=0; fill_count<=DEPTH; state<=TX.
- Frame latency: b_out_notify rises one cycle after the last input transfer.
- b_out_sync is ignored in RX.

State TX:
- b_in_notify=0; b_out and b_out_notify are held stable until acceptance.
- b_in_sync is ignored; b_in is not sampled.
- On an edge with b_out_sync=1: b_out_notify<=0; b_in_notify<=1; fill_count<=0; state<=RX.
- b_out retains its last value after acceptance and is only updated at the next frame completion.
- Back-to-back frames: the earliest next input transfer is the edge after acceptance.

Array persistence:
- ACC_MODE=0: array contents persist between frames and are overwritten element by element.
- ACC_MODE=1: contents accumulate across frames until clear or reset.

clear:
- Has priority over any transfer or acceptance on the same edge.
- Action: array<=0; index<=0; fill_count<=0; b_out<=0; b_out_notify<=0; b_in_notify<=1; state<=RX.
- Clear during TX drops the pending frame.

Boundary cases:
- DEPTH=1: every input transfer moves the block to TX.
- Reset asserted mid-frame or mid-TX: partial data is discarded and all outputs take their reset values immediately.
- Overflow in accumulate mode wraps: 0xFFFFFFFF + 2 = 0x00000001 at ELEM_W=32.

Test Plan:
- Reset, DEPTH=2, ACC_MODE=0 → b_in_notify=1, b_out_notify=0, b_out=0, fill_count=0 while rst low and on the first cycle after release.
- Send 0x11 then 0x22 with b_in_sync held high → fill_count goes 1 then 2; b_out_notify=1 the next cycle; b_out=0x00000022_00000011; b_in_notify=0.
- Hold b_out_sync=0 for 5 cycles while pulsing b_in_sync with 0x99 → b_out stays stable and array unchanged. Then assert b_out_sync → b_out_notify=0 and b_in_notify=1 on the following cycle.
- ACC_MODE=1: frame {5,7}, then frame {0xFFFFFFFF,1} → second b_out has element0=4 and element1=8.
- Assert clear in the same cycle as the second input transfer → fill_count=0, no frame emitted, array=0; next two transfers {3,4} yield b_out=0x00000004_00000003.
- Drop rst during TX with a valid frame → b_out_notify=0, b_out=0, b_in_notify=1 asynchronously, before the next clock edge.
